biu_arbiter: RTL and testbench
==============================

# biu_arbiter

Bus interface arbiter for the V30-class core. It shares the single 16-bit external bus between two requesters: the instruction prefetcher, which feeds the pre-decoder, and the execution unit's memory operands (MEM8/MEM16/MEM32). Each logical access is split into bus cycles by size and address alignment. Results are returned to the requester with a one-cycle acknowledge.

## Interface
- `PF_STARVE_MAX`, default 4: consecutive EU grants allowed while a prefetch is pending (used only with the fairness feature).
- `clk`  in  1  system clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `eu_req`  in  1  EU access request; held until `eu_ack`
- `eu_write`  in  1  1 = write, 0 = read
- `eu_size`  in  2  0 = byte, 1 = word, 2 = dword; 3 is illegal and treated as word
- `eu_addr`  in  20  physical byte address
- `eu_wdata`  in  32  write data, little-endian
- `eu_ack`  out  1  one-cycle pulse: access complete
- `eu_rdata`  out  32  read data; valid with `eu_ack`; byte zero-extended, word in [15:0]
- `pf_req`  in  1  prefetch request; held until `pf_ack`
- `pf_addr`  in  20  physical fetch address
- `pf_flush`  in  1  one-cycle pulse: discard the in-flight prefetch
- `pf_ack`  out  1  one-cycle pulse: fetch data valid
- `pf_rdata`  out  16  fetched bytes; lower address in [7:0]
- `pf_two`  out  1  1 = two bytes valid, 0 = one byte in [7:0]
- `bus_req`  out  1  bus cycle active
- `bus_addr`  out  19  word address (byte address [19:1])
- `bus_be`  out  2  byte enables: [0] low (even) lane, [1] high (odd) lane
- `bus_write`  out  1  write cycle
- `bus_wdata`  out  16  lane-aligned write data
- `bus_rdy`  in  1  bus cycle completes on the edge where it is sampled high
- `bus_rdata`  in  16  lane-aligned read data, valid with `bus_rdy`

## Operation
- **States:** IDLE, PF (single prefetch cycle), EU (1 to 4 sub-cycles tracked by `phase`).
- **Arbitration in IDLE:**
  - EU wins over PF.
  - A request is ignored in the cycle its own ack is high.
- **Prefetch:**
  - Even `pf_addr`: one cycle, `be=11`, `pf_two=1`.
  - Odd `pf_addr`: `be=10`, byte moved to `pf_rdata[7:0]`, `pf_two=0`.
- **EU access decomposition:**
  - An EU access is decomposed into words at addr and, for dword, at addr+2 (mod 2^20).
  - Each word at an odd address is split into a byte at addr (`be=10`) then a byte at addr+1 (`be=01`).
  - Sub-cycle counts:
    - byte: 1
    - even word: 1
    - odd word: 2
    - even dword: 2
    - odd dword: 4
- **Byte lanes:**
  - Even byte: `be=01`, lane [7:0].
  - Odd byte: `be=10`, lane [15:8].
  - Write data is steered to its lane.
  - Read data is gathered into `eu_rdata` in byte-address order.
- **Atomicity:** EU sub-cycles run back-to-back. No prefetch is interleaved inside one EU access.
- **Flush:**
  - A flush during PF lets the bus cycle finish (`bus_req` stays high until `bus_rdy`), then suppresses `pf_ack`.
  - A flush during IDLE or EU has no effect.
  - The prefetcher must not reassert `pf_req` for the flushed fetch after a flush. It may present a new address immediately.
- **Outputs:**
  - `bus_*` outputs are registered.
  - `eu_rdata`/`pf_rdata` hold their last value between acks.

## Timing
- **Reset (async):**
  - All outputs are 0.
  - State is IDLE, `phase`=0, starve counter 0.
  - A reset mid-cycle drops `bus_req` immediately. The access is lost with no ack.
- **Request to bus:** request sampled in IDLE at edge N → `bus_req`=1 from N+1.
- **Sub-cycles:**
  - `bus_rdy` high at edge M completes a sub-cycle.
  - The next sub-cycle's address/be are driven from M+1 with no idle gap.
  - `bus_req` stays high between sub-cycles.
- **Ack:**
  - Final `bus_rdy` at edge M → ack high for cycle M+1.
  - `bus_req` is low in M+1.
  - State is IDLE at M+1, so the earliest new grant is sampled at edge M+2.
- **Minimum latency:** a zero-wait byte/word access takes 3 cycles from request to ack. An odd dword with zero wait takes 6.
- **Wait states:** with `bus_rdy` low, all `bus_*` outputs hold stable.
- **Simultaneous events:**
  - `eu_req` and `pf_req` in the same IDLE cycle → EU granted (subject to Configuration).
  - `pf_flush` together with the final `bus_rdy` of a prefetch → no `pf_ack`.

## Configuration
- **`BIU_PF_FAIRNESS_EN` defined:**
  - A counter increments on each EU grant made while `pf_req` is high.
  - The counter clears on any PF grant, and when `pf_req` is low in IDLE.
  - When the count equals `PF_STARVE_MAX`, the next IDLE arbitration with both requesting grants PF.
- **`BIU_PF_FAIRNESS_EN` not defined:** strict EU priority; no counter logic is present.

## Test plan
- **Even prefetch:** `pf_req`, `pf_addr=0x0F000`, `bus_rdata=0x1234`, zero wait → `bus_addr=0x07800`, `be=11`; `pf_ack` 3 cycles after request with `pf_rdata=0x1234`, `pf_two=1`.
- **Odd EU word read:** `eu_addr=0x00101`, size 1 → cycles at `bus_addr` 0x00080 (`be=10`, rdata 0xAB00) then 0x00081 (`be=01`, rdata 0x00CD); `eu_rdata=0x0000CDAB`.
- **Odd dword write:** `eu_addr=0xFFFFF`, `eu_wdata=0x44332211` → 4 sub-cycles:
  - byte addrs 0xFFFFF (`be=10`, `wdata[15:8]`=0x11)
  - byte addr 0x00000 (`be=01`, `wdata[7:0]`=0x22), showing wrap-around
  - then 0x00001 and 0x00002, carrying 0x33 and 0x44
  - one `eu_ack`.
- **Flush with wait states:** hold `bus_rdy` low 3 cycles during PF, pulse `pf_flush` → bus cycle completes, no `pf_ack`. A new `pf_req` at 0x00200 gets its own ack.
- **Contention:** `eu_req` and `pf_req` held continuously, EU reissued after each ack, `PF_STARVE_MAX=4`:
  - With the macro: PF granted after exactly 4 EU grants.
  - Without the macro: PF never granted.
- **Reset mid-access:** deassert `reset_n` during sub-cycle 2 of a dword → all outputs 0 asynchronously. After release, IDLE, and a fresh byte read completes normally.

Source files
------------

// File: rtl/biu_arbiter.sv
// biu_arbiter: shares the 16-bit external bus between the prefetcher and the EU,
// splitting EU accesses into aligned bus cycles. Define BIU_PF_FAIRNESS_EN to bound prefetch starvation.
module biu_arbiter #(
  parameter int PF_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eu_req,
  input  logic        eu_write,
  input  logic [1:0]  eu_size,
  input  logic [19:0] eu_addr,
  input  logic [31:0] eu_wdata,
  output logic        eu_ack,
  output logic [31:0] eu_rdata,
  input  logic        pf_req,
  input  logic [19:0] pf_addr,
  input  logic        pf_flush,
  output logic        pf_ack,
  output logic [15:0] pf_rdata,
  output logic        pf_two,
  output logic        bus_req,
  output logic [18:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic        bus_write,
  output logic [15:0] bus_wdata,
  input  logic        bus_rdy,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, PF, EU} state_t;

  typedef struct packed {
    logic [18:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } sub_t;

  state_t      state;
  logic [1:0]  phase;
  logic [19:0] acc_addr;
  logic [1:0]  acc_size;
  logic [31:0] acc_wdata;
  logic [31:0] rbuf;
  logic        pf_odd;
  logic        pf_flushed;
  logic        settle;

  logic [1:0]  size_n;
  logic [1:0]  last_phase;
  logic        word_mode;
  logic [31:0] rbuf_next;
  logic        eu_win, pf_win, force_pf;
  logic        grant_eu, grant_pf;
  sub_t        sub_first, sub_next;

  // Aligned word/dword accesses move whole words; everything else moves one byte per phase.
  function automatic sub_t sub_cycle(input logic [19:0] addr, input logic [1:0] size,
                                     input logic [31:0] wdata, input logic [1:0] ph);
    sub_t        s;
    logic [19:0] ba;
    logic [7:0]  b;
    if (size != 2'd0 && !addr[0]) begin
      ba      = addr + {17'd0, ph, 1'b0};
      s.addr  = ba[19:1];
      s.be    = 2'b11;
      s.wdata = ph[0] ? wdata[31:16] : wdata[15:0];
    end else begin
      ba      = addr + {18'd0, ph};
      b       = wdata[{ph, 3'b000} +: 8];
      s.addr  = ba[19:1];
      s.be    = ba[0] ? 2'b10 : 2'b01;
      s.wdata = ba[0] ? {b, 8'h00} : {8'h00, b};
    end
    return s;
  endfunction

  assign size_n    = (eu_size == 2'd3) ? 2'd1 : eu_size;
  assign word_mode = (acc_size != 2'd0) && !acc_addr[0];
  assign sub_first = sub_cycle(eu_addr, size_n, eu_wdata, 2'd0);
  assign sub_next  = sub_cycle(acc_addr, acc_size, acc_wdata, phase + 2'd1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    last_phase = 2'd0;
    case (acc_size)
      2'd1:    last_phase = {1'b0, acc_addr[0]};
      2'd2:    last_phase = acc_addr[0] ? 2'd3 : 2'd1;
      default: last_phase = 2'd0;
    endcase
  end

  always_comb begin
    rbuf_next = rbuf;
    if (word_mode) rbuf_next[{phase[0], 4'b0000} +: 16] = bus_rdata;
    else           rbuf_next[{phase, 3'b000} +: 8] = bus_be[1] ? bus_rdata[15:8] : bus_rdata[7:0];
  end

  // settle marks the cycle after any completion; no grant is made then, which also hides own-ack requests.
  assign eu_win   = eu_req && !eu_ack;
  assign pf_win   = pf_req && !pf_ack;
  assign grant_eu = (state == IDLE) && !settle && eu_win && !(pf_win && force_pf);
  assign grant_pf = (state == IDLE) && !settle && pf_win && !grant_eu;

`ifdef BIU_PF_FAIRNESS_EN
  localparam int CNT_W = $clog2(PF_STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_pf || !pf_req)
        starve_cnt <= '0;
      else if (grant_eu && starve_cnt != CNT_W'(PF_STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_pf = (starve_cnt == CNT_W'(PF_STARVE_MAX));
`else
  assign force_pf = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= 2'd0;
      acc_addr   <= '0;
      acc_size   <= '0;
      acc_wdata  <= '0;
      rbuf       <= '0;
      pf_odd     <= 1'b0;
      pf_flushed <= 1'b0;
      settle     <= 1'b0;
      eu_ack     <= 1'b0;
      eu_rdata   <= '0;
      pf_ack     <= 1'b0;
      pf_rdata   <= '0;
      pf_two     <= 1'b0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_write  <= 1'b0;
      bus_wdata  <= '0;
    end else begin
      eu_ack <= 1'b0;
      pf_ack <= 1'b0;
      settle <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_eu) begin
            acc_addr  <= eu_addr;
            acc_size  <= size_n;
            acc_wdata <= eu_wdata;
            rbuf      <= '0;
            phase     <= 2'd0;
            bus_req   <= 1'b1;
            bus_addr  <= sub_first.addr;
            bus_be    <= sub_first.be;
            bus_write <= eu_write;
            bus_wdata <= eu_write ? sub_first.wdata : 16'h0000;
            state     <= EU;
          end else if (grant_pf) begin
            pf_odd     <= pf_addr[0];
            pf_flushed <= 1'b0;
            bus_req    <= 1'b1;
            bus_addr   <= pf_addr[19:1];
            bus_be     <= pf_addr[0] ? 2'b10 : 2'b11;
            bus_write  <= 1'b0;
            bus_wdata  <= '0;
            state      <= PF;
          end
        end
        PF: begin
          if (pf_flush) pf_flushed <= 1'b1;
          if (bus_rdy) begin
            bus_req  <= 1'b0;
            bus_addr <= '0;
            bus_be   <= '0;
            settle   <= 1'b1;
            state    <= IDLE;
            if (!pf_flushed && !pf_flush) begin
              pf_ack   <= 1'b1;
              pf_rdata <= pf_odd ? {8'h00, bus_rdata[15:8]} : bus_rdata;
              pf_two   <= !pf_odd;
            end
          end
        end
        EU: begin
          if (bus_rdy) begin
            rbuf <= rbuf_next;
            if (phase == last_phase) begin
              if (!bus_write) eu_rdata <= rbuf_next;
              eu_ack    <= 1'b1;
              bus_req   <= 1'b0;
              bus_addr  <= '0;
              bus_be    <= '0;
              bus_write <= 1'b0;
              bus_wdata <= '0;
              settle    <= 1'b1;
              state     <= IDLE;
            end else begin
              phase     <= phase + 2'd1;
              bus_addr  <= sub_next.addr;
              bus_be    <= sub_next.be;
              bus_wdata <= bus_write ? sub_next.wdata : 16'h0000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed testbench for biu_arbiter: a wait-state bus model with word memory,
// a log of completed bus cycles, and one task per scenario.
module tb_biu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eu_req, eu_write;
  logic [1:0]  eu_size;
  logic [19:0] eu_addr;
  logic [31:0] eu_wdata;
  logic        eu_ack;
  logic [31:0] eu_rdata;
  logic        pf_req;
  logic [19:0] pf_addr;
  logic        pf_flush;
  logic        pf_ack;
  logic [15:0] pf_rdata;
  logic        pf_two;
  logic        bus_req;
  logic [18:0] bus_addr;
  logic [1:0]  bus_be;
  logic        bus_write;
  logic [15:0] bus_wdata;
  logic        bus_rdy;
  logic [15:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [18:0] addr;
    logic [1:0]  be;
    logic        wr;
    logic [15:0] wdata;
  } cyc_t;

  cyc_t        log_q[$];
  logic [15:0] mem [logic [18:0]];
  int          wait_states = 0;
  int          wcnt = 0;

  biu_arbiter #(.PF_STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .eu_req(eu_req), .eu_write(eu_write), .eu_size(eu_size), .eu_addr(eu_addr),
    .eu_wdata(eu_wdata), .eu_ack(eu_ack), .eu_rdata(eu_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_flush(pf_flush), .pf_ack(pf_ack),
    .pf_rdata(pf_rdata), .pf_two(pf_two),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_be(bus_be), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdy(bus_rdy), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Bus slave: decides ready on the falling edge so the DUT samples a settled value.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_rdy = 1'b0;
      wcnt    = 0;
    end else if (bus_req) begin
      if (wcnt < wait_states) begin
        bus_rdy = 1'b0;
        wcnt++;
      end else begin
        bus_rdy   = 1'b1;
        bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 16'h0000;
        wcnt      = 0;
      end
    end else begin
      bus_rdy = 1'b0;
      wcnt    = 0;
    end
  end

  always @(posedge clk)
    if (reset_n && bus_req && bus_rdy)
      log_q.push_back('{bus_addr, bus_be, bus_write, bus_wdata});

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // lat counts the request cycle as 1; -1 means the ack never came within budget.
  task automatic wait_ack(input bit is_eu, input int budget, output int lat);
    lat = 1;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (is_eu ? eu_ack : pf_ack) break;
      if (lat > budget) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic eu_issue(input bit wr, input logic [1:0] sz, input logic [19:0] a, input logic [31:0] d);
    eu_req   = 1'b1;
    eu_write = wr;
    eu_size  = sz;
    eu_addr  = a;
    eu_wdata = d;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    eu_req = 0; eu_write = 0; eu_size = 0; eu_addr = 0; eu_wdata = 0;
    pf_req = 0; pf_addr = 0; pf_flush = 0;
    bus_rdata = 0;
    idle(3);
    checks++;
    if ({eu_ack, eu_rdata, pf_ack, pf_rdata, pf_two, bus_req, bus_addr, bus_be, bus_write, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: bus_req=%b bus_addr=%h eu_rdata=%h pf_rdata=%h, expected all zero",
               bus_req, bus_addr, eu_rdata, pf_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: bus_req=%b expected 0", bus_req);
    end
  endtask

  task automatic test_prefetch;
    int lat;
    idle(2);
    pf_req = 1'b1; pf_addr = 20'h0F000;
    @(posedge clk); #1;
    checks++;
    if ({bus_req, bus_addr, bus_be, bus_write} !== {1'b1, 19'h07800, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL pf_even_bus: req=%b addr=%h be=%b wr=%b expected 1 07800 11 0", bus_req, bus_addr, bus_be, bus_write);
    end
    wait_ack(1'b0, 20, lat);
    lat++;  // the bus-cycle edge above was already consumed
    pf_req = 1'b0;
    checks++;
    if (lat !== 3 || pf_rdata !== 16'h1234 || pf_two !== 1'b1 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL pf_even_ack: lat=%0d rdata=%h two=%b bus_req=%b expected 3 1234 1 0", lat, pf_rdata, pf_two, bus_req);
    end
    idle(2);
    pf_req = 1'b1; pf_addr = 20'h00401;
    @(posedge clk); #1;
    checks++;
    if ({bus_addr, bus_be} !== {19'h00200, 2'b10}) begin
      errors++;
      $display("FAIL pf_odd_bus: addr=%h be=%b expected 00200 10", bus_addr, bus_be);
    end
    wait_ack(1'b0, 20, lat);
    pf_req = 1'b0;
    checks++;
    if (lat < 0 || pf_rdata !== 16'h005A || pf_two !== 1'b0) begin
      errors++;
      $display("FAIL pf_odd_ack: lat=%0d rdata=%h two=%b expected 005a 0", lat, pf_rdata, pf_two);
    end
  endtask

  task automatic test_odd_word_read;
    int lat;
    idle(2);
    log_q.delete();
    eu_issue(1'b0, 2'd1, 20'h00101, 32'h0);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (lat !== 4 || eu_rdata !== 32'h0000CDAB) begin
      errors++;
      $display("FAIL odd_word_read: lat=%0d rdata=%h expected 4 0000cdab", lat, eu_rdata);
    end
    checks++;
    if (log_q.size() != 2 || {log_q[0].addr, log_q[0].be, log_q[1].addr, log_q[1].be} !== {19'h00080, 2'b10, 19'h00081, 2'b01}) begin
      errors++;
      $display("FAIL odd_word_cycles: n=%0d c0=%h/%b c1=%h/%b expected 2 00080/10 00081/01",
               log_q.size(), log_q[0].addr, log_q[0].be, log_q[1].addr, log_q[1].be);
    end
  endtask

  task automatic test_odd_dword_write;
    int   lat;
    cyc_t exp_c [4];
    exp_c[0] = '{19'h7FFFF, 2'b10, 1'b1, 16'h1100};
    exp_c[1] = '{19'h00000, 2'b01, 1'b1, 16'h0022};
    exp_c[2] = '{19'h00000, 2'b10, 1'b1, 16'h3300};
    exp_c[3] = '{19'h00001, 2'b01, 1'b1, 16'h0044};
    idle(2);
    log_q.delete();
    eu_issue(1'b1, 2'd2, 20'hFFFFF, 32'h44332211);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (lat !== 6 || log_q.size() != 4) begin
      errors++;
      $display("FAIL odd_dword_lat: lat=%0d cycles=%0d expected 6 4", lat, log_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL odd_dword_cyc%0d: got %h expected %h", i, (log_q.size() > i) ? log_q[i] : '0, exp_c[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (eu_ack !== 1'b0 || eu_rdata !== 32'h0000CDAB) begin
      errors++;
      $display("FAIL odd_dword_single_ack: ack=%b rdata=%h expected 0 0000cdab", eu_ack, eu_rdata);
    end
  endtask

  task automatic test_eu_misc;
    int lat;
    idle(2);
    log_q.delete();
    eu_issue(1'b0, 2'd2, 20'h00200, 32'h0);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (lat !== 4 || eu_rdata !== 32'hCAFEBEEF || log_q.size() != 2 || log_q[1].be !== 2'b11) begin
      errors++;
      $display("FAIL even_dword_read: lat=%0d rdata=%h cycles=%0d expected 4 cafebeef 2", lat, eu_rdata, log_q.size());
    end
    idle(2);
    eu_issue(1'b0, 2'd0, 20'h00203, 32'h0);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (lat !== 3 || eu_rdata !== 32'h000000CA) begin
      errors++;
      $display("FAIL odd_byte_read: lat=%0d rdata=%h expected 3 000000ca", lat, eu_rdata);
    end
    idle(2);
    eu_issue(1'b0, 2'd3, 20'h00200, 32'h0);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (lat !== 3 || eu_rdata !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL size3_as_word: lat=%0d rdata=%h expected 3 0000beef", lat, eu_rdata);
    end
    idle(2);
    log_q.delete();
    eu_issue(1'b1, 2'd1, 20'h00010, 32'h9999A55A);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (log_q.size() != 1 || log_q[0] !== cyc_t'{19'h00008, 2'b11, 1'b1, 16'hA55A}) begin
      errors++;
      $display("FAIL even_word_write: n=%0d got %h expected 1 %h", log_q.size(), log_q[0], cyc_t'{19'h00008, 2'b11, 1'b1, 16'hA55A});
    end
  endtask

  task automatic test_flush;
    int          acks = 0;
    logic [15:0] got_rdata = 16'h0;
    logic        got_two = 1'b0;
    idle(2);
    log_q.delete();
    wait_states = 3;
    pf_req = 1'b1; pf_addr = 20'h00300;
    @(posedge clk); #1;
    pf_flush = 1'b1;
    pf_addr  = 20'h00200;
    @(posedge clk); #1;
    pf_flush = 1'b0;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 19'h00180) begin
      errors++;
      $display("FAIL flush_hold: bus_req=%b addr=%h expected 1 00180", bus_req, bus_addr);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (pf_ack) begin
        acks++;
        got_rdata = pf_rdata;
        got_two   = pf_two;
        pf_req    = 1'b0;
      end
    end
    checks++;
    if (acks != 1 || got_rdata !== 16'hBEEF || got_two !== 1'b1) begin
      errors++;
      $display("FAIL flush_acks: acks=%0d rdata=%h two=%b expected 1 beef 1", acks, got_rdata, got_two);
    end
    checks++;
    if (log_q.size() != 2 || log_q[0].addr !== 19'h00180 || log_q[1].addr !== 19'h00100) begin
      errors++;
      $display("FAIL flush_cycles: n=%0d a0=%h a1=%h expected 2 00180 00100", log_q.size(), log_q[0].addr, log_q[1].addr);
    end
    wait_states = 0;
  endtask

  task automatic test_contention;
    int         lat;
    int         n = 0;
    logic [18:0] exp_a;
    idle(2);
    log_q.delete();
    eu_issue(1'b0, 2'd0, 20'h00010, 32'h0);
    pf_req = 1'b1; pf_addr = 20'h00400;
    while (log_q.size() < 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    eu_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef BIU_PF_FAIRNESS_EN
      exp_a = (i == 4) ? 19'h00200 : 19'h00008;
`else
      exp_a = 19'h00008;
`endif
      checks++;
      if (log_q.size() <= i || log_q[i].addr !== exp_a) begin
        errors++;
        $display("FAIL contention_grant%0d: addr=%h expected %h", i, (log_q.size() > i) ? log_q[i].addr : 19'h0, exp_a);
      end
    end
    wait_ack(1'b0, 30, lat);
    pf_req = 1'b0;
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL contention_pf_after: lat=%0d expected an ack", lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int n = 0;
    bit busy = 1'b0;
    idle(2);
    log_q.delete();
    wait_states = 2;
    eu_issue(1'b0, 2'd2, 20'h00200, 32'h0);
    while (log_q.size() < 1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    #3;
    reset_n = 1'b0;
    eu_req  = 1'b0;
    #1;
    checks++;
    if ({eu_ack, eu_rdata, pf_ack, pf_rdata, pf_two, bus_req, bus_addr, bus_be, bus_write, bus_wdata} !== '0 || n >= 20) begin
      errors++;
      $display("FAIL reset_mid_outputs: bus_req=%b addr=%h be=%b eu_rdata=%h n=%0d expected all zero",
               bus_req, bus_addr, bus_be, eu_rdata, n);
    end
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    wait_states = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus_req || eu_ack) busy = 1'b1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_lost: activity=%b expected 0", busy);
    end
    eu_issue(1'b0, 2'd0, 20'h00201, 32'h0);
    wait_ack(1'b1, 20, lat);
    eu_req = 1'b0;
    checks++;
    if (lat !== 3 || eu_rdata !== 32'h000000BE) begin
      errors++;
      $display("FAIL reset_mid_fresh: lat=%0d rdata=%h expected 3 000000be", lat, eu_rdata);
    end
  endtask

  initial begin
    mem[19'h07800] = 16'h1234;
    mem[19'h00200] = 16'h5A77;
    mem[19'h00080] = 16'hAB00;
    mem[19'h00081] = 16'h00CD;
    mem[19'h00100] = 16'hBEEF;
    mem[19'h00101] = 16'hCAFE;
    mem[19'h00180] = 16'h1111;
    test_reset;
    test_prefetch;
    test_odd_word_read;
    test_odd_dword_write;
    test_eu_misc;
    test_flush;
    test_contention;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
